// File: rtl/CacheTypes.sv
// Shared instruction-cache bus types: line address, line width and memory beat.
package CacheTypes;

  localparam int unsigned ICACHE_MEM_ADDR_WIDTH = 28;
  localparam int unsigned ICACHE_LINE_WIDTH     = 128;
  localparam int unsigned ICACHE_BEAT_WIDTH     = 32;

  typedef logic [ICACHE_MEM_ADDR_WIDTH-1:0] icache_mem_addr_t;
  typedef logic [ICACHE_LINE_WIDTH-1:0]     icache_line_t;
  typedef logic [ICACHE_BEAT_WIDTH-1:0]     bus_beat_t;

endpackage

// File: rtl/icache_bus_responder.sv
// Splits icache line reads/writes into BEAT_WIDTH memory beats, one beat in flight at a time.
// Optional stall watchdog enabled by defining ICACHE_BUS_RESPONDER_TIMEOUT_EN.
module icache_bus_responder
  import CacheTypes::*;
#(
  parameter int unsigned LINE_WIDTH     = ICACHE_LINE_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH = ICACHE_MEM_ADDR_WIDTH,
  parameter int unsigned BEAT_WIDTH     = ICACHE_BEAT_WIDTH,
  localparam int unsigned NBEATS        = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned BEAT_IDX_W    = $clog2(NBEATS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MEM_ADDR_WIDTH-1:0]        icAddr,
  input  logic                             icReadReq,
  output logic                             icReadGrant,
  output logic [LINE_WIDTH-1:0]            icReadValue,
  input  logic                             icWriteReq,
  input  logic [LINE_WIDTH-1:0]            icWriteValue,
  output logic                             icWriteGrant,
  output logic [MEM_ADDR_WIDTH+BEAT_IDX_W-1:0] memAddr,
  output logic                             memReadReq,
  output logic                             memWriteReq,
  output logic [BEAT_WIDTH-1:0]            memWriteData,
  input  logic                             memAck,
  input  logic [BEAT_WIDTH-1:0]            memReadData
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
  ,
  output logic                             timeoutError
`endif
);

  typedef enum logic [1:0] {Idle, Read, Write, Grant} state_e;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NBEATS - 1);

  state_e                    stateQ, stateD;
  logic [BEAT_IDX_W-1:0]     beatQ, beatD;
  logic [MEM_ADDR_WIDTH-1:0] addrQ, addrD;
  logic [LINE_WIDTH-1:0]     lineQ, lineD;
  logic                      isWriteQ, isWriteD;
  logic                      dropLine;

  logic                                 readGrantD, writeGrantD;
  logic                                 memReadReqD, memWriteReqD;
  logic [MEM_ADDR_WIDTH+BEAT_IDX_W-1:0] memAddrD;
  logic [BEAT_WIDTH-1:0]                memWriteDataD;
  logic [LINE_WIDTH-1:0]                readValueD;

`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;
  logic [7:0] toCntQ, toCntD;
  logic       timedOutQ, timedOutD;
  logic       timeoutErrQ, timeoutErrD;
  assign timeoutError = timeoutErrQ;
`endif

  always_comb begin
    stateD   = stateQ;
    beatD    = beatQ;
    addrD    = addrQ;
    lineD    = lineQ;
    isWriteD = isWriteQ;
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
    toCntD      = toCntQ;
    timedOutD   = timedOutQ;
    timeoutErrD = timeoutErrQ;
`endif

    unique case (stateQ)
      Idle: begin
        if (icWriteReq) begin
          stateD   = Write;
          addrD    = icAddr;
          lineD    = icWriteValue;
          beatD    = '0;
          isWriteD = 1'b1;
        end else if (icReadReq) begin
          stateD   = Read;
          addrD    = icAddr;
          beatD    = '0;
          isWriteD = 1'b0;
        end
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
        toCntD    = '0;
        timedOutD = 1'b0;
`endif
      end
      Read, Write: begin
        if (memAck) begin
          if (stateQ == Read) begin
            lineD[int'(beatQ)*BEAT_WIDTH +: BEAT_WIDTH] = memReadData;
          end
          beatD = beatQ + BEAT_IDX_W'(1);
          if (beatQ == LAST_BEAT) begin
            stateD = Grant;
          end
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
          toCntD = '0;
        end else if (toCntQ == TIMEOUT_LAST) begin
          // 255th consecutive stall cycle: give up and grant with an empty line.
          toCntD      = toCntQ + 8'd1;
          stateD      = Grant;
          beatD       = '0;
          timedOutD   = 1'b1;
          timeoutErrD = 1'b1;
        end else begin
          toCntD = toCntQ + 8'd1;
`endif
        end
      end
      Grant: begin
        stateD = Idle;
      end
      default: begin
        stateD = Idle;
      end
    endcase

`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
    dropLine = timedOutD;
`else
    dropLine = 1'b0;
`endif

    // Outputs are computed from next state so the registered copies line up with the state.
    memReadReqD   = (stateD == Read);
    memWriteReqD  = (stateD == Write);
    memAddrD      = (memReadReqD || memWriteReqD) ? {addrD, beatD} : '0;
    memWriteDataD = memWriteReqD ? lineD[int'(beatD)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    readGrantD    = (stateD == Grant) && !isWriteD;
    writeGrantD   = (stateD == Grant) && isWriteD;
    readValueD    = (readGrantD && !dropLine) ? lineD : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ       <= Idle;
      beatQ        <= '0;
      addrQ        <= '0;
      lineQ        <= '0;
      isWriteQ     <= 1'b0;
      icReadGrant  <= 1'b0;
      icWriteGrant <= 1'b0;
      icReadValue  <= '0;
      memReadReq   <= 1'b0;
      memWriteReq  <= 1'b0;
      memAddr      <= '0;
      memWriteData <= '0;
    end else begin
      stateQ       <= stateD;
      beatQ        <= beatD;
      addrQ        <= addrD;
      lineQ        <= lineD;
      isWriteQ     <= isWriteD;
      icReadGrant  <= readGrantD;
      icWriteGrant <= writeGrantD;
      icReadValue  <= readValueD;
      memReadReq   <= memReadReqD;
      memWriteReq  <= memWriteReqD;
      memAddr      <= memAddrD;
      memWriteData <= memWriteDataD;
    end
  end

`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCntQ      <= '0;
      timedOutQ   <= 1'b0;
      timeoutErrQ <= 1'b0;
    end else begin
      toCntQ      <= toCntD;
      timedOutQ   <= timedOutD;
      timeoutErrQ <= timeoutErrD;
    end
  end
`endif

endmodule

// File: tb/tb_icache_bus_responder.sv
// Directed bench for icache_bus_responder; covers the timeout path when
// ICACHE_BUS_RESPONDER_TIMEOUT_EN is defined.
module tb_icache_bus_responder;

  localparam logic [127:0] EXP_LINE = 128'h44444444_33333333_22222222_11111111;

  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  icAddr;
  logic         icReadReq;
  logic         icReadGrant;
  logic [127:0] icReadValue;
  logic         icWriteReq;
  logic [127:0] icWriteValue;
  logic         icWriteGrant;
  logic [29:0]  memAddr;
  logic         memReadReq;
  logic         memWriteReq;
  logic [31:0]  memWriteData;
  logic         memAck;
  logic [31:0]  memReadData;
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
  logic         timeoutError;
`endif

  int tests = 0;
  int fails = 0;

  int           readGrantCyc;
  int           writeGrantCyc;
  int           unstable;
  logic [127:0] readLine;
  logic [29:0]  rdAddrLog[$];
  logic [29:0]  wrAddrLog[$];
  logic [31:0]  wrDataLog[$];

  always #5 clk = ~clk;

  icache_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .icAddr       (icAddr),
    .icReadReq    (icReadReq),
    .icReadGrant  (icReadGrant),
    .icReadValue  (icReadValue),
    .icWriteReq   (icWriteReq),
    .icWriteValue (icWriteValue),
    .icWriteGrant (icWriteGrant),
    .memAddr      (memAddr),
    .memReadReq   (memReadReq),
    .memWriteReq  (memWriteReq),
    .memWriteData (memWriteData),
    .memAck       (memAck),
    .memReadData  (memReadData)
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
    ,
    .timeoutError (timeoutError)
`endif
  );

  // Memory model: acks each beat after ackDelay wait cycles, read data 0x11111111*(beat+1).
  // Cycle 1 is the cycle in which the caller presented the request.
  task automatic run_bus(input int maxCyc, input int ackDelay);
    int          waitCnt = 0;
    logic        prevWaiting = 1'b0;
    logic [29:0] prevAddr = '0;
    readGrantCyc  = 0;
    writeGrantCyc = 0;
    unstable      = 0;
    readLine      = '0;
    rdAddrLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    for (int k = 1; k <= maxCyc; k++) begin
      @(posedge clk);
      #1;
      if (prevWaiting && !(icReadGrant || icWriteGrant) &&
          (memAddr !== prevAddr || !(memReadReq || memWriteReq))) begin
        unstable++;
      end
      if (icWriteGrant) begin
        writeGrantCyc = k + 1;
        icWriteReq = 1'b0;
      end
      if (icReadGrant) begin
        readGrantCyc = k + 1;
        readLine = icReadValue;
        icReadReq = 1'b0;
      end
      memAck = 1'b0;
      prevWaiting = 1'b0;
      if ((icReadGrant || icWriteGrant) && !icReadReq && !icWriteReq) break;
      if (memReadReq || memWriteReq) begin
        memReadData = 32'h11111111 * (32'(memAddr[1:0]) + 32'd1);
        if (waitCnt == ackDelay) begin
          memAck = 1'b1;
          waitCnt = 0;
          if (memReadReq) rdAddrLog.push_back(memAddr);
          if (memWriteReq) begin
            wrAddrLog.push_back(memAddr);
            wrDataLog.push_back(memWriteData);
          end
        end else begin
          waitCnt++;
          prevWaiting = 1'b1;
          prevAddr = memAddr;
        end
      end
    end
    memAck = 1'b0;
    icReadReq = 1'b0;
    icWriteReq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (icReadGrant !== 1'b0) begin fails++; $display("FAIL reset_icReadGrant: got %b expected 0", icReadGrant); end
    tests++; if (icWriteGrant !== 1'b0) begin fails++; $display("FAIL reset_icWriteGrant: got %b expected 0", icWriteGrant); end
    tests++; if (memReadReq !== 1'b0) begin fails++; $display("FAIL reset_memReadReq: got %b expected 0", memReadReq); end
    tests++; if (memWriteReq !== 1'b0) begin fails++; $display("FAIL reset_memWriteReq: got %b expected 0", memWriteReq); end
    tests++; if (memAddr !== 30'h0) begin fails++; $display("FAIL reset_memAddr: got %h expected 0", memAddr); end
    tests++; if (memWriteData !== 32'h0) begin fails++; $display("FAIL reset_memWriteData: got %h expected 0", memWriteData); end
    tests++; if (icReadValue !== 128'h0) begin fails++; $display("FAIL reset_icReadValue: got %h expected 0", icReadValue); end
    rst = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    icAddr = 28'h0000010;
    icReadReq = 1'b1;
    run_bus(40, 0);
    tests++; if (readGrantCyc != 6) begin fails++; $display("FAIL read_grant_cycle: got %0d expected 6", readGrantCyc); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL read_value: got %h expected %h", readLine, EXP_LINE); end
    tests++; if (rdAddrLog.size() != 4) begin fails++; $display("FAIL read_beat_count: got %0d expected 4", rdAddrLog.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rdAddrLog[i] !== 30'h40 + 30'(i)) begin
        fails++; $display("FAIL read_addr_beat%0d: got %h expected %h", i, rdAddrLog[i], 30'h40 + 30'(i));
      end
    end
    @(posedge clk); #1;
    tests++; if (icReadGrant !== 1'b0) begin fails++; $display("FAIL read_grant_pulse: got %b expected 0", icReadGrant); end
  endtask

  task automatic test_write_priority();
    @(posedge clk); #1;
    icAddr = 28'h5;
    icWriteValue = {4{32'hDDDDDDDD}};
    icWriteReq = 1'b1;
    icReadReq = 1'b1;
    run_bus(60, 0);
    tests++; if (writeGrantCyc != 6) begin fails++; $display("FAIL prio_write_grant_cycle: got %0d expected 6", writeGrantCyc); end
    tests++; if (readGrantCyc != 12) begin fails++; $display("FAIL prio_read_grant_cycle: got %0d expected 12", readGrantCyc); end
    tests++; if (wrAddrLog.size() != 4) begin fails++; $display("FAIL prio_write_beats: got %0d expected 4", wrAddrLog.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wrAddrLog[i] !== 30'h14 + 30'(i) || wrDataLog[i] !== 32'hDDDDDDDD) begin
        fails++; $display("FAIL prio_write_beat%0d: got addr %h data %h expected addr %h data DDDDDDDD",
                          i, wrAddrLog[i], wrDataLog[i], 30'h14 + 30'(i));
      end
    end
    tests++; if (rdAddrLog[0] !== 30'h14) begin fails++; $display("FAIL prio_read_addr: got %h expected 14", rdAddrLog[0]); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL prio_read_value: got %h expected %h", readLine, EXP_LINE); end
  endtask

  task automatic test_write_slices();
    @(posedge clk); #1;
    icAddr = 28'h7;
    icWriteValue = EXP_LINE;
    icWriteReq = 1'b1;
    run_bus(60, 1);
    tests++; if (writeGrantCyc != 10) begin fails++; $display("FAIL wslice_grant_cycle: got %0d expected 10", writeGrantCyc); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wrAddrLog[i] !== 30'h1C + 30'(i) || wrDataLog[i] !== 32'h11111111 * 32'(i + 1)) begin
        fails++; $display("FAIL wslice_beat%0d: got addr %h data %h expected addr %h data %h",
                          i, wrAddrLog[i], wrDataLog[i], 30'h1C + 30'(i), 32'h11111111 * 32'(i + 1));
      end
    end
  endtask

  task automatic test_delayed_ack();
    @(posedge clk); #1;
    icAddr = 28'h123;
    icReadReq = 1'b1;
    run_bus(80, 3);
    tests++; if (readGrantCyc != 18) begin fails++; $display("FAIL delay_grant_cycle: got %0d expected 18", readGrantCyc); end
    tests++; if (unstable != 0) begin fails++; $display("FAIL delay_stable: got %0d changes expected 0", unstable); end
    tests++; if (rdAddrLog[3] !== 30'h48F) begin fails++; $display("FAIL delay_last_addr: got %h expected 48f", rdAddrLog[3]); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL delay_value: got %h expected %h", readLine, EXP_LINE); end
  endtask

  task automatic test_drop_req();
    @(posedge clk); #1;
    icAddr = 28'h2;
    icReadReq = 1'b1;
    @(posedge clk); #1;
    icReadReq = 1'b0;
    // memAck was low for the first Read cycle, so the grant lands one edge later.
    run_bus(40, 0);
    tests++; if (readGrantCyc != 6) begin fails++; $display("FAIL drop_grant_cycle: got %0d expected 6", readGrantCyc); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL drop_value: got %h expected %h", readLine, EXP_LINE); end
  endtask

  task automatic test_ack_idle();
    memAck = 1'b1;
    memReadData = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (memReadReq || memWriteReq || icReadGrant || icWriteGrant) begin
        fails++; $display("FAIL idle_ack_cycle%0d: got rd %b wr %b rg %b wg %b expected all 0",
                          i, memReadReq, memWriteReq, icReadGrant, icWriteGrant);
      end
    end
    memAck = 1'b0;
    icAddr = 28'h9;
    icReadReq = 1'b1;
    run_bus(40, 0);
    tests++; if (rdAddrLog[0] !== 30'h24) begin fails++; $display("FAIL idle_ack_first_addr: got %h expected 24", rdAddrLog[0]); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL idle_ack_value: got %h expected %h", readLine, EXP_LINE); end
  endtask

  task automatic test_reset_midxfer();
    logic seen = 1'b0;
    @(posedge clk); #1;
    icAddr = 28'h33;
    icReadReq = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (memReadReq && memAddr[1:0] == 2'd2) begin
        seen = 1'b1;
        break;
      end
      memAck = memReadReq;
      memReadData = 32'h11111111 * (32'(memAddr[1:0]) + 32'd1);
    end
    memAck = 1'b0;
    tests++; if (!seen) begin fails++; $display("FAIL midrst_reach_beat2: got 0 expected 1"); end
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if (memReadReq || memWriteReq || icReadGrant || icWriteGrant || memAddr !== 30'h0 ||
        memWriteData !== 32'h0 || icReadValue !== 128'h0) begin
      fails++; $display("FAIL midrst_async_clear: got rd %b wr %b addr %h expected all 0",
                        memReadReq, memWriteReq, memAddr);
    end
    #2;
    rst = 1'b1;
    run_bus(40, 0);
    tests++; if (readGrantCyc != 6) begin fails++; $display("FAIL midrst_grant_cycle: got %0d expected 6", readGrantCyc); end
    tests++; if (rdAddrLog[0] !== 30'hCC) begin fails++; $display("FAIL midrst_restart_addr: got %h expected cc", rdAddrLog[0]); end
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL midrst_value: got %h expected %h", readLine, EXP_LINE); end
  endtask

`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
  task automatic test_timeout();
    tests++; if (timeoutError !== 1'b0) begin fails++; $display("FAIL timeout_initial: got %b expected 0", timeoutError); end
    @(posedge clk); #1;
    icAddr = 28'h44;
    icReadReq = 1'b1;
    run_bus(300, 100000);
    tests++; if (readGrantCyc != 257) begin fails++; $display("FAIL timeout_grant_cycle: got %0d expected 257", readGrantCyc); end
    tests++; if (readLine !== 128'h0) begin fails++; $display("FAIL timeout_value: got %h expected 0", readLine); end
    tests++; if (timeoutError !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b expected 1", timeoutError); end
    icAddr = 28'h10;
    icReadReq = 1'b1;
    run_bus(40, 0);
    tests++; if (readLine !== EXP_LINE) begin fails++; $display("FAIL timeout_next_value: got %h expected %h", readLine, EXP_LINE); end
    tests++; if (timeoutError !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", timeoutError); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (timeoutError !== 1'b0) begin fails++; $display("FAIL timeout_reset_clear: got %b expected 0", timeoutError); end
    rst = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b0;
    icAddr = '0;
    icReadReq = 1'b0;
    icWriteReq = 1'b0;
    icWriteValue = '0;
    memAck = 1'b0;
    memReadData = '0;
    test_reset();
    test_read();
    test_write_priority();
    test_write_slices();
    test_delayed_ack();
    test_drop_req();
    test_ack_idle();
    test_reset_midxfer();
`ifdef ICACHE_BUS_RESPONDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
